// File: rtl/eth_phy_10g_rx_link_ctrl_pkg.sv
// Shared constants, state encoding and header helper for the 10G BASE-R RX link controller.
package eth_phy_10g_rx_link_ctrl_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam int unsigned BER_THRESH = 16;
    localparam int unsigned BER_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_ACQUIRE   = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_link_ctrl_ber_mon.sv
// 125 us window BER monitor: counts invalid sync headers per window and tracks
// consecutive high-BER windows for escalation.
module eth_phy_10g_rx_ber_mon
    import eth_phy_10g_rx_link_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_125US     = 19531,
    parameter int unsigned MAX_BAD_WINDOWS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hdr_ok,
    output logic high_ber,
    output logic high_ber_next_c,
    output logic escalate_c
);

    localparam int unsigned WIN_W = $clog2(COUNT_125US);
    localparam int unsigned BAD_W = $clog2(MAX_BAD_WINDOWS + 1);

    logic [WIN_W-1:0]     win_cnt;
    logic [BER_CNT_W-1:0] ber_count;
    logic [BER_CNT_W-1:0] ber_inc;
    logic [BAD_W-1:0]     bad_windows;
    logic                 window_end;
    logic                 ber_full;

    // Header count including this cycle's header, saturating at the threshold.
    always_comb begin
        window_end = (win_cnt == '0);
        ber_inc    = ber_count;
        if (!hdr_ok && (ber_count < BER_CNT_W'(BER_THRESH))) begin
            ber_inc = ber_count + BER_CNT_W'(1);
        end
        ber_full        = (ber_inc == BER_CNT_W'(BER_THRESH));
        escalate_c      = window_end && ber_full &&
                          (bad_windows == BAD_W'(MAX_BAD_WINDOWS - 1));
        high_ber_next_c = !clear && (ber_full || (high_ber && !window_end));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt     <= WIN_W'(COUNT_125US - 1);
            ber_count   <= '0;
            bad_windows <= '0;
            high_ber    <= 1'b0;
        end else if (clear) begin
            win_cnt     <= WIN_W'(COUNT_125US - 1);
            ber_count   <= '0;
            bad_windows <= '0;
            high_ber    <= 1'b0;
        end else begin
            high_ber <= high_ber_next_c;
            if (window_end) begin
                win_cnt   <= WIN_W'(COUNT_125US - 1);
                ber_count <= '0;
                if (ber_full) begin
                    bad_windows <= bad_windows + BAD_W'(1);
                end else begin
                    bad_windows <= '0;
                end
            end else begin
                win_cnt   <= win_cnt - WIN_W'(1);
                ber_count <= ber_inc;
            end
        end
    end

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10G BASE-R RX link controller: SERDES reset sequencing, block-lock acquisition
// and high-BER escalation. Optional error counter via ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN.
module eth_phy_10g_rx_link_ctrl
    import eth_phy_10g_rx_link_ctrl_pkg::*;
#(
    parameter int unsigned HDR_WIDTH           = 2,
    parameter int unsigned COUNT_125US         = 19531,
    parameter int unsigned SERDES_RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT        = 65535,
    parameter int unsigned MAX_BAD_WINDOWS     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
    input  logic                 serdes_rx_reset_done,
    input  logic                 rx_block_lock,
    output logic                 serdes_rx_reset_req,
    output logic                 rx_frame_sync_rst,
    output logic                 rx_high_ber,
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
    output logic                 rx_status,
    output logic [15:0]          rx_error_count
`else
    output logic                 rx_status
`endif
);

    if (HDR_WIDTH != 2) begin : g_hdr_width_chk
        $error("eth_phy_10g_rx_link_ctrl: HDR_WIDTH must be 2");
    end

    localparam int unsigned RST_W  = $clog2(SERDES_RESET_CYCLES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT);

    state_t            state, state_next;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_next;
    logic [LOCK_W-1:0] lock_timer, lock_timer_next;
    logic              hdr_ok;
    logic              mon_clear;
    logic              high_ber_next;
    logic              escalate;

    assign hdr_ok = hdr_valid(2'(serdes_rx_hdr));

    eth_phy_10g_rx_ber_mon #(
        .COUNT_125US     (COUNT_125US),
        .MAX_BAD_WINDOWS (MAX_BAD_WINDOWS)
    ) u_ber_mon (
        .clk             (clk),
        .rst             (rst),
        .clear           (mon_clear),
        .hdr_ok          (hdr_ok),
        .high_ber        (rx_high_ber),
        .high_ber_next_c (high_ber_next),
        .escalate_c      (escalate)
    );

    // Next state; reset_done loss beats escalation, which beats lock loss.
    always_comb begin
        state_next      = state;
        rst_cnt_next    = '0;
        lock_timer_next = '0;
        case (state)
            ST_RESET: begin
                if (rst_cnt == RST_W'(SERDES_RESET_CYCLES - 1)) begin
                    state_next = ST_WAIT_DONE;
                end else begin
                    rst_cnt_next = rst_cnt + RST_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (serdes_rx_reset_done) begin
                    state_next = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (!serdes_rx_reset_done) begin
                    state_next = ST_RESET;
                end else if (rx_block_lock) begin
                    state_next = ST_LOCKED;
                end else if (lock_timer == LOCK_W'(LOCK_TIMEOUT - 1)) begin
                    state_next = ST_RESET;
                end else begin
                    lock_timer_next = lock_timer + LOCK_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!serdes_rx_reset_done || escalate) begin
                    state_next = ST_RESET;
                end else if (!rx_block_lock) begin
                    state_next = ST_ACQUIRE;
                end
            end
            default: state_next = ST_RESET;
        endcase
        // Monitor runs only while staying in LOCKED; anything else restarts it.
        mon_clear = (state != ST_LOCKED) || (state_next != ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= ST_RESET;
            rst_cnt             <= '0;
            lock_timer          <= '0;
            serdes_rx_reset_req <= 1'b1;
            rx_frame_sync_rst   <= 1'b1;
            rx_status           <= 1'b0;
        end else begin
            state               <= state_next;
            rst_cnt             <= rst_cnt_next;
            lock_timer          <= lock_timer_next;
            serdes_rx_reset_req <= (state_next == ST_RESET);
            rx_frame_sync_rst   <= (state_next == ST_RESET) || (state_next == ST_WAIT_DONE);
            rx_status           <= (state_next == ST_LOCKED) && !high_ber_next;
        end
    end

`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
    // Lifetime count of invalid headers seen while locked; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_error_count <= '0;
        end else if ((state == ST_LOCKED) && !hdr_ok && (rx_error_count != 16'hFFFF)) begin
            rx_error_count <= rx_error_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Directed self-checking bench for eth_phy_10g_rx_link_ctrl with a 64-cycle BER window.
module tb_eth_phy_10g_rx_link_ctrl;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] hdr  = 2'b01;
    logic       done = 1'b0;
    logic       lock = 1'b0;
    logic       req;
    logic       fs_rst;
    logic       hb;
    logic       status;
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    eth_phy_10g_rx_link_ctrl #(
        .HDR_WIDTH           (2),
        .COUNT_125US         (64),
        .SERDES_RESET_CYCLES (4),
        .LOCK_TIMEOUT        (200),
        .MAX_BAD_WINDOWS     (3)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .serdes_rx_hdr        (hdr),
        .serdes_rx_reset_done (done),
        .rx_block_lock        (lock),
        .serdes_rx_reset_req  (req),
        .rx_frame_sync_rst    (fs_rst),
        .rx_high_ber          (hb),
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
        .rx_status            (status),
        .rx_error_count       (err_cnt)
`else
        .rx_status            (status)
`endif
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // n cycles; the first n_bad carry invalid headers (00/11), the rest valid (01/10).
    task automatic run_cycles(input int n, input int n_bad);
        for (int i = 0; i < n; i++) begin
            if (i < n_bad) hdr = (i % 2 == 1) ? 2'b11 : 2'b00;
            else           hdr = (i % 2 == 1) ? 2'b10 : 2'b01;
            tick();
        end
        hdr = 2'b01;
    endtask

    initial begin
        // Asynchronous reset values before any clock edge
        #1 rst = 1'b1;
        #1;
        check1("rst_req", req, 1'b1);
        check1("rst_fs_rst", fs_rst, 1'b1);
        check1("rst_high_ber", hb, 1'b0);
        check1("rst_status", status, 1'b0);
        ticks(3);
        rst = 1'b0;

        // 1: bring-up
        ticks(3);
        check1("req_held_3", req, 1'b1);
        tick();
        check1("req_fall_4", req, 1'b0);
        check1("fs_rst_wait_done", fs_rst, 1'b1);
        ticks(6);
        done = 1'b1;
        check1("fs_rst_before_done", fs_rst, 1'b1);
        tick();
        check1("fs_rst_fall_11", fs_rst, 1'b0);
        check1("status_acquire", status, 1'b0);
        ticks(19);
        lock = 1'b1;
        check1("status_before_lock", status, 1'b0);
        tick();
        check1("status_rise", status, 1'b1);

        // 2: 15 errors stay below threshold, 16 trip it, clean window clears it
        run_cycles(15, 15);
        check1("hb_15_bad", hb, 1'b0);
        run_cycles(49, 0);
        check1("hb_after_15_window", hb, 1'b0);
        check1("status_after_15_window", status, 1'b1);
        run_cycles(15, 15);
        check1("hb_before_16th", hb, 1'b0);
        run_cycles(1, 1);
        check1("hb_after_16th", hb, 1'b1);
        check1("status_drop_16th", status, 1'b0);
        run_cycles(48, 0);
        check1("hb_hold_window_end", hb, 1'b1);
        run_cycles(63, 0);
        check1("hb_hold_clean_window", hb, 1'b1);
        run_cycles(1, 0);
        check1("hb_clear_clean_end", hb, 1'b0);
        check1("status_restore", status, 1'b1);

        // 3: three consecutive bad windows escalate to SERDES reset
        run_cycles(64, 16);
        run_cycles(64, 16);
        check1("hb_two_bad_windows", hb, 1'b1);
        check1("req_two_bad_windows", req, 1'b0);
        run_cycles(63, 16);
        check1("req_before_escalate", req, 1'b0);
        run_cycles(1, 0);
        check1("req_escalate", req, 1'b1);
        check1("fs_rst_escalate", fs_rst, 1'b1);
        check1("hb_escalate", hb, 1'b0);
        check1("status_escalate", status, 1'b0);
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
        check16("err_cnt_79", err_cnt, 16'd79);
`endif

        // 4: lock timeout in ACQUIRE
        lock = 1'b0;
        ticks(3);
        check1("req_reset_hold", req, 1'b1);
        tick();
        check1("req_wait_done", req, 1'b0);
        check1("fs_rst_wait_done2", fs_rst, 1'b1);
        tick();
        check1("fs_rst_acquire2", fs_rst, 1'b0);
        ticks(199);
        check1("req_before_timeout", req, 1'b0);
        tick();
        check1("req_timeout", req, 1'b1);
        check1("fs_rst_timeout", fs_rst, 1'b1);

        // 5: lock loss coincident with window end
        ticks(5);
        lock = 1'b1;
        tick();
        check1("status_relock", status, 1'b1);
        run_cycles(63, 16);
        check1("hb_before_lockloss", hb, 1'b1);
        lock = 1'b0;
        tick();
        check1("status_lockloss", status, 1'b0);
        check1("hb_lockloss", hb, 1'b0);
        check1("fs_rst_lockloss", fs_rst, 1'b0);
        check1("req_lockloss", req, 1'b0);
        lock = 1'b1;
        tick();
        check1("status_relock2", status, 1'b1);
        run_cycles(15, 15);
        check1("hb_ber_cleared", hb, 1'b0);
        check1("status_ber_cleared", status, 1'b1);
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
        check16("err_cnt_110", err_cnt, 16'd110);
`endif

        // 6: asynchronous reset mid-LOCKED
        ticks(5);
        #3 rst = 1'b1;
        #1;
        check1("async_req", req, 1'b1);
        check1("async_fs_rst", fs_rst, 1'b1);
        check1("async_hb", hb, 1'b0);
        check1("async_status", status, 1'b0);
`ifdef ETH_PHY_RX_LINK_CTRL_ERR_CNT_EN
        check16("async_err_cnt", err_cnt, 16'd0);
`endif
        lock = 1'b0;
        tick();
        rst = 1'b0;
        ticks(3);
        check1("restart_req_held", req, 1'b1);
        tick();
        check1("restart_req_fall", req, 1'b0);
        tick();
        check1("restart_acquire", fs_rst, 1'b0);

        // reset_done loss outranks a simultaneous lock
        done = 1'b0;
        lock = 1'b1;
        tick();
        check1("done_drop_req", req, 1'b1);
        check1("done_drop_status", status, 1'b0);
        check1("done_drop_fs_rst", fs_rst, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
